// File: rtl/motion_seg_sched.sv
// Motion segment scheduler: queues dt/steps/ctrl segments in a circular FIFO and
// feeds them one at a time to the step generator, handling program end, underrun and abort.
module motion_seg_sched #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       seg_wr,
    input  logic [31:0]                seg_dt,
    input  logic [31:0]                seg_steps,
    input  logic [31:0]                seg_ctrl,
    input  logic                       start,
    input  logic                       abort_req,
    input  logic                       clear_err,
    input  logic                       gen_done,
    output logic [31:0]                gen_dt_val,
    output logic [31:0]                gen_steps_val,
    output logic [31:0]                gen_ctrl,
    output logic                       gen_load,
    output logic                       gen_abort,
    output logic                       busy,
    output logic                       seg_full,
    output logic [$clog2(DEPTH):0]     seg_count,
    output logic                       seg_done,
    output logic                       prog_done,
    output logic                       underrun,
    output logic                       overflow,
    output logic [15:0]                seg_index
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, ABORT} state_t;

    state_t          state_reg;
    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   tail_reg;
    logic [CW-1:0]   count_reg;

    logic [31:0] dt_mem    [DEPTH];
    logic [31:0] steps_mem [DEPTH];
    logic [31:0] ctrl_mem  [DEPTH];

    logic abort_take;
    logic full;
    logic pop;
    logic push;
    logic wr_drop;
    logic run_done;
    logic underrun_set;

    // An accepted abort wins over everything else in that cycle, including pushes.
    assign abort_take   = abort_req && (state_reg == LOAD || state_reg == RUN);
    assign full         = (count_reg == CW'(DEPTH));
    assign pop          = (state_reg == LOAD) && !abort_take;
    assign push         = seg_wr && !abort_take && (!full || pop);
    assign wr_drop      = seg_wr && !abort_take && full && !pop;
    assign run_done     = (state_reg == RUN) && gen_done && !abort_take;
    assign underrun_set = run_done && !gen_ctrl[31] && (count_reg == '0);

    assign busy      = (state_reg != IDLE);
    assign seg_full  = full;
    assign seg_count = count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            dt_mem[tail_reg]    <= seg_dt;
            steps_mem[tail_reg] <= seg_steps;
            ctrl_mem[tail_reg]  <= seg_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            gen_dt_val    <= '0;
            gen_steps_val <= '0;
            gen_ctrl      <= '0;
            gen_load      <= 1'b0;
            gen_abort     <= 1'b0;
            seg_done      <= 1'b0;
            prog_done     <= 1'b0;
            underrun      <= 1'b0;
            overflow      <= 1'b0;
            seg_index     <= '0;
        end else begin
            gen_load  <= 1'b0;
            gen_abort <= 1'b0;
            seg_done  <= 1'b0;
            prog_done <= 1'b0;
            // A new error in the same cycle as clear_err keeps the flag set.
            overflow  <= (overflow & ~clear_err) | wr_drop;
            underrun  <= (underrun & ~clear_err) | underrun_set;

            if (abort_take) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (push) tail_reg <= tail_reg + PW'(1);
                if (pop)  head_reg <= head_reg + PW'(1);
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + CW'(1);
                    2'b01:   count_reg <= count_reg - CW'(1);
                    default: count_reg <= count_reg;
                endcase
            end

            case (state_reg)
                IDLE: begin
                    if (start && count_reg != '0) begin
                        seg_index <= '0;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort_take) begin
                        gen_abort <= 1'b1;
                        state_reg <= ABORT;
                    end else begin
                        gen_dt_val    <= dt_mem[head_reg];
                        gen_steps_val <= steps_mem[head_reg];
                        gen_ctrl      <= ctrl_mem[head_reg];
                        gen_load      <= 1'b1;
                        seg_index     <= seg_index + 16'd1;
                        state_reg     <= RUN;
                    end
                end
                RUN: begin
                    if (abort_take) begin
                        gen_abort <= 1'b1;
                        state_reg <= ABORT;
                    end else if (gen_done) begin
                        seg_done <= 1'b1;
                        if (gen_ctrl[31]) begin
                            prog_done <= 1'b1;
                            state_reg <= IDLE;
                        end else if (count_reg != '0) begin
                            state_reg <= LOAD;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                ABORT: begin
                    if (gen_done) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_motion_seg_sched.sv
// Scoreboard bench for motion_seg_sched: a queue of expected segments is filled as
// pushes are accepted and drained by a monitor on every gen_load.
module tb_motion_seg_sched;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [31:0] LAST = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic seg_wr = 1'b0, start = 1'b0, abort_req = 1'b0, clear_err = 1'b0, gen_done = 1'b0;
    logic [31:0] seg_dt = '0, seg_steps = '0, seg_ctrl = '0;
    logic [31:0] gen_dt_val, gen_steps_val, gen_ctrl;
    logic gen_load, gen_abort, busy, seg_full, seg_done, prog_done, underrun, overflow;
    logic [CW-1:0] seg_count;
    logic [15:0] seg_index;

    motion_seg_sched #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .seg_wr(seg_wr), .seg_dt(seg_dt), .seg_steps(seg_steps),
        .seg_ctrl(seg_ctrl), .start(start), .abort_req(abort_req), .clear_err(clear_err),
        .gen_done(gen_done), .gen_dt_val(gen_dt_val), .gen_steps_val(gen_steps_val),
        .gen_ctrl(gen_ctrl), .gen_load(gen_load), .gen_abort(gen_abort), .busy(busy),
        .seg_full(seg_full), .seg_count(seg_count), .seg_done(seg_done), .prog_done(prog_done),
        .underrun(underrun), .overflow(overflow), .seg_index(seg_index)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] dt; logic [31:0] steps; logic [31:0] ctrl; } seg_t;
    seg_t exp_q[$];

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    int seg_done_cnt = 0, prog_cnt = 0, abort_cnt = 0;
    int loads_since_start = 0;
    int last_done_cyc = 0;
    bit first_load = 1'b1;
    bit auto_gen = 1'b1;
    int gen_lat = 10;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Generator model: answers each gen_load with gen_done after gen_lat cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (gen_load && auto_gen) begin
                repeat (gen_lat) @(posedge clk);
                #1 gen_done = 1'b1;
                @(posedge clk);
                #1 gen_done = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every gen_load and counts the pulse outputs.
    initial begin
        bit prev_load;
        seg_t e;
        prev_load = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_load = 1'b0;
                continue;
            end
            if (gen_abort) abort_cnt++;
            if (seg_done)  seg_done_cnt++;
            if (prog_done) prog_cnt++;
            if (gen_load) begin
                check("gen_load_width", {31'd0, prev_load}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_load: actual gen_load=1 dt=%0d required no load", gen_dt_val);
                end else begin
                    e = exp_q.pop_front();
                    loads_since_start++;
                    check("load_dt", gen_dt_val, e.dt);
                    check("load_steps", gen_steps_val, e.steps);
                    check("load_ctrl", gen_ctrl, e.ctrl);
                    check("load_index", {16'd0, seg_index}, 32'(loads_since_start & 16'hFFFF));
                    if (!first_load) check("load_spacing", 32'(cyc - last_done_cyc), 32'd2);
                    first_load = 1'b0;
                    $display("load idx=%0d dt=%0d steps=%0d ctrl=0x%0h", seg_index, gen_dt_val,
                             gen_steps_val, gen_ctrl);
                end
            end
            if (gen_done) last_done_cyc = cyc;
            prev_load = gen_load;
        end
    end

    task automatic push(logic [31:0] dt, logic [31:0] st, logic [31:0] ct, bit accept);
        seg_wr = 1'b1; seg_dt = dt; seg_steps = st; seg_ctrl = ct;
        @(posedge clk);
        #1 seg_wr = 1'b0;
        if (accept) exp_q.push_back('{dt, st, ct});
        $display("push dt=%0d steps=%0d ctrl=0x%0h accepted=%0d", dt, st, ct, accept);
    endtask

    // Pushes while idle: accepted exactly when the model queue has room.
    task automatic push_idle(logic [31:0] dt, logic [31:0] st, logic [31:0] ct);
        push(dt, st, ct, exp_q.size() < DEPTH);
    endtask

    task automatic do_start();
        loads_since_start = 0;
        first_load = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(posedge clk);
        #1 clear_err = 1'b0;
    endtask

    task automatic wait_idle(string name, int maxc);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: actual busy=1 after %0d cycles required idle", name, maxc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_load(string name, int maxc);
        int n;
        n = 0;
        @(negedge clk);
        while (!gen_load && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (!gen_load) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: actual no gen_load in %0d cycles required gen_load", name, maxc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(string tag);
        check({tag, "_dt"}, gen_dt_val, 32'd0);
        check({tag, "_steps"}, gen_steps_val, 32'd0);
        check({tag, "_ctrl"}, gen_ctrl, 32'd0);
        check({tag, "_strobes"}, {28'd0, gen_load, gen_abort, seg_done, prog_done}, 32'd0);
        check({tag, "_flags"}, {29'd0, busy, underrun, overflow}, 32'd0);
        check({tag, "_full"}, {31'd0, seg_full}, 32'd0);
        check({tag, "_count"}, 32'(seg_count), 32'd0);
        check({tag, "_index"}, {16'd0, seg_index}, 32'd0);
    endtask

    initial begin
        int sd0, pd0, ab0, n, bound;
        logic [31:0] ct;
        bit seen;

        // Reset state
        #12 check_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three-segment program
        sd0 = seg_done_cnt; pd0 = prog_cnt;
        push_idle(100, 1, 32'h0);
        push_idle(200, 2, 32'h0);
        push_idle(300, 3, LAST);
        check("prog3_count", 32'(seg_count), 32'd3);
        do_start();
        wait_idle("prog3_idle", 200);
        check("prog3_seg_done", 32'(seg_done_cnt - sd0), 32'd3);
        check("prog3_prog_done", 32'(prog_cnt - pd0), 32'd1);
        check("prog3_index", {16'd0, seg_index}, 32'd3);
        check("prog3_hold_dt", gen_dt_val, 32'd300);
        check("prog3_drained", 32'(exp_q.size()), 32'd0);

        // Overflow then push coincident with the LOAD pop at full
        for (int i = 0; i < DEPTH; i++)
            push_idle(32'(1000 + i), 32'(i), (i == DEPTH - 1) ? LAST : 32'(i));
        push_idle(9999, 9, LAST);
        check("ovf_full", {31'd0, seg_full}, 32'd1);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_count", 32'(seg_count), 32'(DEPTH));
        pulse_clear();
        check("ovf_cleared", {31'd0, overflow}, 32'd0);
        do_start();
        push(5000, 50, LAST, 1'b1);
        check("coinc_count", 32'(seg_count), 32'(DEPTH));
        check("coinc_no_ovf", {31'd0, overflow}, 32'd0);
        wait_idle("coinc_idle", 300);
        check("coinc_left", 32'(seg_count), 32'd1);
        do_start();
        wait_idle("coinc_idle2", 100);
        check("coinc_dt", gen_dt_val, 32'd5000);
        check("coinc_empty", 32'(seg_count), 32'd0);

        // Underrun
        sd0 = seg_done_cnt; pd0 = prog_cnt;
        push_idle(77, 7, 32'h0);
        do_start();
        wait_idle("ur_idle", 100);
        check("ur_flag", {31'd0, underrun}, 32'd1);
        check("ur_seg_done", 32'(seg_done_cnt - sd0), 32'd1);
        check("ur_no_prog", 32'(prog_cnt - pd0), 32'd0);
        pulse_clear();
        check("ur_cleared", {31'd0, underrun}, 32'd0);

        // Abort in IDLE is ignored
        ab0 = abort_cnt;
        abort_req = 1'b1;
        @(posedge clk);
        #1 abort_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_idle_ignored", 32'(abort_cnt - ab0), 32'd0);

        // Abort during RUN with two segments queued, push in the abort cycle dropped
        sd0 = seg_done_cnt; pd0 = prog_cnt; ab0 = abort_cnt;
        push_idle(10, 1, 32'h0);
        push_idle(20, 2, 32'h0);
        push_idle(30, 3, LAST);
        do_start();
        wait_load("abort_load", 20);
        repeat (2) @(posedge clk);
        #1;
        check("abort_pre_count", 32'(seg_count), 32'd2);
        abort_req = 1'b1; seg_wr = 1'b1; seg_dt = 40;
        @(posedge clk);
        #1 abort_req = 1'b0; seg_wr = 1'b0;
        exp_q.delete();
        check("abort_pulse", {31'd0, gen_abort}, 32'd1);
        check("abort_flush", 32'(seg_count), 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd1);
        seen = 1'b0;
        bound = 0;
        while (!seen && bound < 30) begin
            @(negedge clk);
            bound++;
            if (gen_done) begin
                seen = 1'b1;
                check("abort_busy_at_done", {31'd0, busy}, 32'd1);
            end
        end
        check("abort_done_seen", {31'd0, seen}, 32'd1);
        @(negedge clk);
        check("abort_idle", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        check("abort_no_seg_done", 32'(seg_done_cnt - sd0), 32'd0);
        check("abort_no_prog", 32'(prog_cnt - pd0), 32'd0);
        check("abort_once", 32'(abort_cnt - ab0), 32'd1);
        @(posedge clk);
        #1;

        // Randomized programs
        for (int r = 0; r < 8; r++) begin
            pd0 = prog_cnt;
            n = $urandom_range(1, DEPTH);
            gen_lat = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                ct = $urandom() & 32'h7FFF_FFFF;
                if (i == n - 1) ct = ct | LAST;
                push_idle($urandom(), $urandom(), ct);
            end
            do_start();
            wait_idle("rand_idle", 300);
            check("rand_index", {16'd0, seg_index}, 32'(n));
            check("rand_prog", 32'(prog_cnt - pd0), 32'd1);
            check("rand_empty", 32'(seg_count), 32'd0);
        end
        gen_lat = 10;

        // Reset mid-RUN
        ab0 = abort_cnt;
        push_idle(600, 6, 32'h0);
        push_idle(700, 7, LAST);
        do_start();
        wait_load("rst_load", 20);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        exp_q.delete();
        #1 check_zero("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("midrst_no_abort", 32'(abort_cnt - ab0), 32'd0);
        check("midrst_count", 32'(seg_count), 32'd0);
        do_start();
        repeat (3) begin
            @(negedge clk);
            check("empty_start_idle", {31'd0, busy}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: actual time limit reached required test end");
        $fatal(1, "timeout");
    end
endmodule
